// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: captures the EX payload, inserts bubbles on flush or
// an invalid EX slot, holds on stall, and keeps saturating bubble/stall counters.
module ex_mem_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        exValid,
    input  logic [31:0] exInstruction,
    input  logic [4:0]  exWriteReg,
    input  logic        exMemRead,
    input  logic        exMemWrite,
    input  logic [31:0] exALUOut,
    input  logic [31:0] exNewPC,
    input  logic [31:0] exRtData,
    output logic        memValid,
    output logic        memMemRead,
    output logic        memMemWrite,
    output logic [4:0]  memWriteReg,
    output logic [31:0] memInstruction,
    output logic [31:0] memALUOut,
    output logic [31:0] memNewPC,
    output logic [31:0] memRtData,
    output logic        memLoadPending,
    output logic [31:0] bubbleCount,
    output logic [31:0] stallCount
);

    typedef struct packed {
        logic        valid;
        logic [31:0] instruction;
        logic [4:0]  write_reg;
        logic        mem_read;
        logic        mem_write;
        logic [31:0] alu_out;
        logic [31:0] new_pc;
        logic [31:0] rt_data;
    } stage_t;

    // All-zero payload: invalid, no destination, no memory access, NOP word.
    localparam stage_t BUBBLE = '0;

    typedef enum logic [1:0] {
        ACT_BUBBLE,
        ACT_HOLD,
        ACT_CAPTURE
    } action_e;

    stage_t      stage_q, stage_d;
    stage_t      ex_stage;
    action_e     action;
    logic [31:0] bubble_count_q, bubble_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    always_comb begin
        ex_stage.valid       = 1'b1;
        ex_stage.instruction = exInstruction;
        ex_stage.write_reg   = exWriteReg;
        ex_stage.mem_read    = exMemRead;
        ex_stage.mem_write   = exMemWrite;
        ex_stage.alu_out     = exALUOut;
        ex_stage.new_pc      = exNewPC;
        ex_stage.rt_data     = exRtData;
    end

    // Flush beats stall, stall beats capture; reset is applied in the flop block.
    always_comb begin
        if (flush)        action = ACT_BUBBLE;
        else if (stall)   action = ACT_HOLD;
        else if (exValid) action = ACT_CAPTURE;
        else              action = ACT_BUBBLE;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        stage_d        = stage_q;
        bubble_count_d = bubble_count_q;
        stall_count_d  = stall_count_q;

        unique case (action)
            ACT_BUBBLE: begin
                stage_d = BUBBLE;
                if (bubble_count_q != '1) bubble_count_d = bubble_count_q + 32'd1;
            end
            ACT_HOLD: begin
                if (stall_count_q != '1) stall_count_d = stall_count_q + 32'd1;
            end
            ACT_CAPTURE: begin
                stage_d = ex_stage;
            end
            default: stage_d = BUBBLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            stage_q        <= BUBBLE;
            bubble_count_q <= '0;
            stall_count_q  <= '0;
        end else begin
            stage_q        <= stage_d;
            bubble_count_q <= bubble_count_d;
            stall_count_q  <= stall_count_d;
        end
    end

    assign memValid       = stage_q.valid;
    assign memInstruction = stage_q.instruction;
    assign memWriteReg    = stage_q.write_reg;
    assign memMemRead     = stage_q.mem_read;
    assign memMemWrite    = stage_q.mem_write;
    assign memALUOut      = stage_q.alu_out;
    assign memNewPC       = stage_q.new_pc;
    assign memRtData      = stage_q.rt_data;
    assign bubbleCount    = bubble_count_q;
    assign stallCount     = stall_count_q;

    // Decoded straight from the register so load-use detection sees it this cycle.
    assign memLoadPending = stage_q.valid & stage_q.mem_read;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed, table-driven bench for ex_mem_reg: each vector applies one edge of
// inputs and compares every registered output against hand-computed values.
module tb_ex_mem_reg;

    logic        clk = 1'b0;
    logic        reset, stall, flush, exValid;
    logic [31:0] exInstruction, exALUOut, exNewPC, exRtData;
    logic [4:0]  exWriteReg;
    logic        exMemRead, exMemWrite;
    logic        memValid, memMemRead, memMemWrite, memLoadPending;
    logic [4:0]  memWriteReg;
    logic [31:0] memInstruction, memALUOut, memNewPC, memRtData;
    logic [31:0] bubbleCount, stallCount;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_mem_reg dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .exValid(exValid),
        .exInstruction(exInstruction), .exWriteReg(exWriteReg),
        .exMemRead(exMemRead), .exMemWrite(exMemWrite),
        .exALUOut(exALUOut), .exNewPC(exNewPC), .exRtData(exRtData),
        .memValid(memValid), .memMemRead(memMemRead), .memMemWrite(memMemWrite),
        .memWriteReg(memWriteReg), .memInstruction(memInstruction),
        .memALUOut(memALUOut), .memNewPC(memNewPC), .memRtData(memRtData),
        .memLoadPending(memLoadPending),
        .bubbleCount(bubbleCount), .stallCount(stallCount)
    );

    typedef struct {
        logic        rst, stl, fl, ev;
        logic [31:0] i;
        logic [4:0]  w;
        logic        mr, mw;
        logic [31:0] a, p, d;
        logic        x_valid;
        logic [4:0]  x_wr;
        logic        x_mr, x_mw;
        logic [31:0] x_instr, x_alu, x_pc, x_rt;
        logic        x_lp;
        logic [31:0] x_bc, x_sc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic rst, stl, fl, ev, input logic [31:0] i, input logic [4:0] w,
        input logic mr, mw, input logic [31:0] a, p, d,
        input logic xv, input logic [4:0] xw, input logic xmr, xmw,
        input logic [31:0] xi, xa, xp, xd, input logic xlp, input logic [31:0] xbc, xsc);
        vec_t v;
        v.rst = rst; v.stl = stl; v.fl = fl; v.ev = ev;
        v.i = i; v.w = w; v.mr = mr; v.mw = mw; v.a = a; v.p = p; v.d = d;
        v.x_valid = xv; v.x_wr = xw; v.x_mr = xmr; v.x_mw = xmw;
        v.x_instr = xi; v.x_alu = xa; v.x_pc = xp; v.x_rt = xd;
        v.x_lp = xlp; v.x_bc = xbc; v.x_sc = xsc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset = v.rst; stall = v.stl; flush = v.fl; exValid = v.ev;
        exInstruction = v.i; exWriteReg = v.w; exMemRead = v.mr; exMemWrite = v.mw;
        exALUOut = v.a; exNewPC = v.p; exRtData = v.d;
    endtask

    task automatic check_vec(input int k, input vec_t v);
        string t;
        t = $sformatf("v%0d", k);
        check({t, " memValid"},       32'(memValid),       32'(v.x_valid));
        check({t, " memWriteReg"},    32'(memWriteReg),    32'(v.x_wr));
        check({t, " memMemRead"},     32'(memMemRead),     32'(v.x_mr));
        check({t, " memMemWrite"},    32'(memMemWrite),    32'(v.x_mw));
        check({t, " memInstruction"}, memInstruction,      v.x_instr);
        check({t, " memALUOut"},      memALUOut,           v.x_alu);
        check({t, " memNewPC"},       memNewPC,            v.x_pc);
        check({t, " memRtData"},      memRtData,           v.x_rt);
        check({t, " memLoadPending"}, 32'(memLoadPending), 32'(v.x_lp));
        check({t, " bubbleCount"},    bubbleCount,         v.x_bc);
        check({t, " stallCount"},     stallCount,          v.x_sc);
    endtask

    initial begin
        vec_t idle;
        //          rst stl fl ev  instr          wr  mr mw alu            pc            rt
        //          -> valid wr mr mw instr       alu           pc            rt            lp bc  sc
        // v0: reset wins over a valid EX slot
        vecs.push_back(mk(1,0,0,1, 32'hDEADBEEF, 7, 1,0, 32'h1, 32'h2, 32'h3,
                          0, 0, 0,0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0));
        // v1: plain capture
        vecs.push_back(mk(0,0,0,1, 32'h00A42820, 5, 0,0, 32'h12345678, 32'h104, 32'hAA,
                          1, 5, 0,0, 32'h00A42820, 32'h12345678, 32'h104, 32'hAA, 0, 0, 0));
        // v2: load captured
        vecs.push_back(mk(0,0,0,1, 32'h8D080000, 8, 1,0, 32'h2000, 32'h108, 32'h0,
                          1, 8, 1,0, 32'h8D080000, 32'h2000, 32'h108, 32'h0, 1, 0, 0));
        // v3..v5: three stalls with changing EX inputs hold the load
        vecs.push_back(mk(0,1,0,1, 32'h11111111, 3, 0,1, 32'h3, 32'h3, 32'h3,
                          1, 8, 1,0, 32'h8D080000, 32'h2000, 32'h108, 32'h0, 1, 0, 1));
        vecs.push_back(mk(0,1,0,0, 32'h22222222, 4, 0,0, 32'h4, 32'h4, 32'h4,
                          1, 8, 1,0, 32'h8D080000, 32'h2000, 32'h108, 32'h0, 1, 0, 2));
        vecs.push_back(mk(0,1,0,1, 32'h33333333, 31, 1,1, 32'h5, 32'h5, 32'h5,
                          1, 8, 1,0, 32'h8D080000, 32'h2000, 32'h108, 32'h0, 1, 0, 3));
        // v6: valid state with destination 9
        vecs.push_back(mk(0,0,0,1, 32'h01095020, 9, 0,0, 32'h55, 32'h10C, 32'h77,
                          1, 9, 0,0, 32'h01095020, 32'h55, 32'h10C, 32'h77, 0, 0, 3));
        // v7: stall and flush together -> bubble only
        vecs.push_back(mk(0,1,1,1, 32'h44444444, 10, 1,1, 32'h4, 32'h4, 32'h4,
                          0, 0, 0,0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 1, 3));
        // v8: invalid EX slot with a destination and load flag
        vecs.push_back(mk(0,0,0,0, 32'hAC000000, 31, 1,0, 32'h5, 32'h5, 32'h5,
                          0, 0, 0,0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 2, 3));
        // v9: writeReg 0 kept, read+write both passed through
        vecs.push_back(mk(0,0,0,1, 32'h00000020, 0, 1,1, 32'h99, 32'h110, 32'h11,
                          1, 0, 1,1, 32'h00000020, 32'h99, 32'h110, 32'h11, 1, 2, 3));
        // v10: stall holds
        vecs.push_back(mk(0,1,0,1, 32'h0, 1, 0,0, 32'h0, 32'h0, 32'h0,
                          1, 0, 1,1, 32'h00000020, 32'h99, 32'h110, 32'h11, 1, 2, 4));
        // v11: reset during stall clears state and counters
        vecs.push_back(mk(1,1,0,1, 32'h66666666, 6, 1,1, 32'h6, 32'h6, 32'h6,
                          0, 0, 0,0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0));
        // v12: first capture after reset
        vecs.push_back(mk(0,0,0,1, 32'h12345678, 3, 0,1, 32'h1, 32'h2, 32'h3,
                          1, 3, 0,1, 32'h12345678, 32'h1, 32'h2, 32'h3, 0, 0, 0));
        // v13: flush with invalid EX
        vecs.push_back(mk(0,0,1,0, 32'h77777777, 7, 1,0, 32'h7, 32'h7, 32'h7,
                          0, 0, 0,0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 1, 0));
        // v14: load captured
        vecs.push_back(mk(0,0,0,1, 32'h8C430004, 2, 1,0, 32'h10, 32'h20, 32'h30,
                          1, 2, 1,0, 32'h8C430004, 32'h10, 32'h20, 32'h30, 1, 1, 0));
        // v15: reset during flush
        vecs.push_back(mk(1,0,1,1, 32'h88888888, 8, 0,0, 32'h8, 32'h8, 32'h8,
                          0, 0, 0,0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0));
        // v16: flush over a valid EX slot
        vecs.push_back(mk(0,0,1,1, 32'h99999999, 9, 1,1, 32'h9, 32'h9, 32'h9,
                          0, 0, 0,0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 1, 0));

        idle = vecs[0];
        drive(idle);
        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            drive(vecs[k]);
            @(posedge clk);
            #1;
            check_vec(k, vecs[k]);
        end

        // Saturation: preload stallCount near its ceiling, then keep stalling.
        force dut.stall_count_q = 32'hFFFF_FFFE;
        #2;
        release dut.stall_count_q;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            reset = 1'b0; stall = 1'b1; flush = 1'b0; exValid = 1'b1;
            exWriteReg = 5'd12; exMemRead = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("sat%0d stallCount", n), stallCount, 32'hFFFF_FFFF);
            check($sformatf("sat%0d bubbleCount", n), bubbleCount, 32'd1);
            check($sformatf("sat%0d memValid", n), 32'(memValid), 32'd0);
        end

        // Reset still clears a saturated counter.
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("sat reset stallCount", stallCount, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
